// File: rtl/dft_tap_table_rx.sv
// dft_tap_table_rx: captures a DFT (delay, obj_id) tap stream into a latency-adjusted per-object table
// Ports: CLK/reset (sync, active-high); arm starts a capture; in_valid + delay_matrix_element +
// obj_id_element deliver one pair; hardware_latency is subtracted from each delay; rd_en/rd_obj_id
// read the table with one-cycle latency into rd_valid/rd_delay/rd_present; capture_busy and
// table_complete report progress; dup_err/underflow_err/overflow_err/timeout_err are sticky until arm.
module dft_tap_table_rx #(
  parameter int delay_length = 14,
  parameter int obj_id_width = 2,
  parameter int N_obj = 4,
  parameter logic [delay_length-1:0] sentinel = 14'h3fff,
  parameter int timeout_cycles = 64,
  parameter int timeout_width = 7
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    in_valid,
  input  logic [delay_length-1:0] delay_matrix_element,
  input  logic [obj_id_width-1:0] obj_id_element,
  input  logic [delay_length-1:0] hardware_latency,
  input  logic                    rd_en,
  input  logic [obj_id_width-1:0] rd_obj_id,
  output logic                    rd_valid,
  output logic [delay_length-1:0] rd_delay,
  output logic                    rd_present,
  output logic                    capture_busy,
  output logic                    table_complete,
  output logic                    dup_err,
  output logic                    underflow_err,
  output logic                    overflow_err,
  output logic                    timeout_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [obj_id_width:0] CNT_LAST = (obj_id_width+1)'(N_obj - 1);
  localparam logic [timeout_width-1:0] WD_LAST = timeout_width'(timeout_cycles - 1);
  logic [1:0]              r_state, w_state;
  logic [delay_length-1:0] r_tab [N_obj];
  logic [delay_length-1:0] w_tab [N_obj];
  logic [N_obj-1:0]        r_wr, w_wr, r_pres, w_pres;
  logic [obj_id_width:0]   r_cnt, w_cnt;
  logic [timeout_width-1:0] r_wd, w_wd;
  logic [3:0]              r_err, w_err;
  logic                    w_sent, w_low;
  logic [delay_length-1:0] w_adj;
  assign w_sent = delay_matrix_element == sentinel;
  assign w_low  = delay_matrix_element < hardware_latency;
  assign w_adj  = w_sent ? sentinel : w_low ? '0 : delay_matrix_element - hardware_latency;
  assign capture_busy   = r_state == S_CAP;
  assign table_complete = r_state == S_DONE;
  assign {dup_err, underflow_err, overflow_err, timeout_err} = r_err;
  always_comb begin
    w_state = r_state;
    w_tab   = r_tab;
    w_wr    = r_wr;
    w_pres  = r_pres;
    w_cnt   = r_cnt;
    w_wd    = r_wd;
    w_err   = r_err;
    if (arm) begin
      w_wr    = '0;
      w_pres  = '0;
      w_cnt   = '0;
      w_wd    = '0;
      w_err   = '0;
      w_state = S_CAP;
    end else if (r_state == S_CAP && in_valid) begin
      w_tab[obj_id_element]  = w_adj;
      w_pres[obj_id_element] = !w_sent;
      w_wr[obj_id_element]   = 1'b1;
      w_wd     = '0;
      w_err[2] = r_err[2] | (w_low & !w_sent);
      if (r_wr[obj_id_element]) w_err[3] = 1'b1;
      else begin
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state = S_DONE;
      end
    end else if (r_state == S_CAP) begin
      w_wd     = r_wd == WD_LAST ? '0 : r_wd + 1'b1;
      w_state  = r_wd == WD_LAST ? S_IDLE : S_CAP;
      w_err[0] = r_err[0] | (r_wd == WD_LAST);
    end else if (r_state == S_DONE && in_valid) w_err[1] = 1'b1;
  end
  // Read port samples the next-state table so a same-cycle write (or arm clear) is seen immediately.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < N_obj; i++) r_tab[i] <= '0;
      r_wr       <= '0;
      r_pres     <= '0;
      r_cnt      <= '0;
      r_wd       <= '0;
      r_err      <= '0;
      rd_valid   <= 1'b0;
      rd_delay   <= '0;
      rd_present <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_tab    <= w_tab;
      r_wr     <= w_wr;
      r_pres   <= w_pres;
      r_cnt    <= w_cnt;
      r_wd     <= w_wd;
      r_err    <= w_err;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_delay   <= w_tab[rd_obj_id];
        rd_present <= w_pres[rd_obj_id];
      end
    end
  end
endmodule

// File: tb/tb_dft_tap_table_rx.sv
// tb_dft_tap_table_rx: scenario and randomized checks of dft_tap_table_rx against a behavioural model
module tb_dft_tap_table_rx;
  logic        CLK = 1'b0;
  logic        reset, arm, in_valid, rd_en;
  logic [13:0] delay_matrix_element, hardware_latency;
  logic [1:0]  obj_id_element, rd_obj_id;
  logic        rd_valid, rd_present, capture_busy, table_complete;
  logic        dup_err, underflow_err, overflow_err, timeout_err;
  logic [13:0] rd_delay;
  logic [5:0]  st_act;
  logic [15:0] rd_act;
  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] m_tab [4];
  logic [3:0]  m_pres, m_wr;
  int          m_cnt, m_wd, m_state;
  logic        m_dup, m_uf, m_ovf, m_to, m_rdv, m_rdp;
  logic [13:0] m_rdd;
  always #5 CLK = ~CLK;
  assign st_act = {capture_busy, table_complete, dup_err, underflow_err, overflow_err, timeout_err};
  assign rd_act = {rd_valid, rd_present, rd_delay};
  dft_tap_table_rx dut (
    .CLK(CLK), .reset(reset), .arm(arm), .in_valid(in_valid),
    .delay_matrix_element(delay_matrix_element), .obj_id_element(obj_id_element),
    .hardware_latency(hardware_latency), .rd_en(rd_en), .rd_obj_id(rd_obj_id),
    .rd_valid(rd_valid), .rd_delay(rd_delay), .rd_present(rd_present),
    .capture_busy(capture_busy), .table_complete(table_complete), .dup_err(dup_err),
    .underflow_err(underflow_err), .overflow_err(overflow_err), .timeout_err(timeout_err)
  );
  function automatic logic [5:0] m_status();
    return {m_state == 1, m_state == 2, m_dup, m_uf, m_ovf, m_to};
  endfunction
  function automatic logic [15:0] m_rd();
    return {m_rdv, m_rdp, m_rdd};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tab[i] = '0;
    {m_pres, m_wr} = '0;
    {m_cnt, m_wd, m_state} = '0;
    {m_dup, m_uf, m_ovf, m_to, m_rdv, m_rdp} = '0;
    m_rdd = '0;
  endtask
  task automatic step(input logic a, input logic v, input logic [1:0] id, input logic [13:0] d,
                      input logic re, input logic [1:0] rid);
    arm = a; in_valid = v; obj_id_element = id; delay_matrix_element = d; rd_en = re; rd_obj_id = rid;
    @(posedge CLK); #1;
    arm = 0; in_valid = 0; rd_en = 0;
    if (a) begin
      {m_pres, m_wr} = '0;
      m_cnt = 0; m_wd = 0; m_state = 1;
      {m_dup, m_uf, m_ovf, m_to} = '0;
    end else if (m_state == 1 && v) begin
      if (d == 14'h3fff) begin m_tab[id] = d; m_pres[id] = 0; end
      else if (d >= hardware_latency) begin m_tab[id] = d - hardware_latency; m_pres[id] = 1; end
      else begin m_tab[id] = 0; m_pres[id] = 1; m_uf = 1; end
      if (m_wr[id]) m_dup = 1;
      else begin m_wr[id] = 1; m_cnt++; if (m_cnt == 4) m_state = 2; end
      m_wd = 0;
    end else if (m_state == 1) begin
      m_wd++;
      if (m_wd == 64) begin m_state = 0; m_to = 1; m_wd = 0; end
    end else if (m_state == 2 && v) m_ovf = 1;
    m_rdv = re;
    if (re) begin m_rdd = m_tab[rid]; m_rdp = m_pres[rid]; end
  endtask
  task automatic do_reset();
    reset = 1; arm = 0; in_valid = 0; rd_en = 0;
    @(posedge CLK); #1;
    reset = 0;
    model_reset();
  endtask
  task automatic do_arm(); step(1, 0, 0, 0, 0, 0); endtask
  task automatic send(input logic [1:0] id, input logic [13:0] d); step(0, 1, id, d, 0, 0); endtask
  task automatic rd(input logic [1:0] id); step(0, 0, 0, 0, 1, id); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0); endtask
  task automatic test_reset();
    delay_matrix_element = 0; obj_id_element = 0; rd_obj_id = 0; hardware_latency = 0;
    do_reset(); do_reset();
    n_cmp++; if (st_act !== 6'b0) begin n_bad++; $display("FAIL reset_status got %b want %b", st_act, 6'b0); end
    n_cmp++; if (rd_act !== 16'h0) begin n_bad++; $display("FAIL reset_rd got %h want %h", rd_act, 16'h0); end
    rd(2);
    n_cmp++; if (rd_act !== 16'h8000) begin n_bad++; $display("FAIL reset_read got %h want %h", rd_act, 16'h8000); end
    idle(1);
    n_cmp++; if (st_act !== m_status()) begin n_bad++; $display("FAIL idle_ignores status got %b want %b", st_act, m_status()); end
  endtask
  task automatic test_basic();
    logic [13:0] want [4];
    logic [3:0]  wpres;
    want[0] = 14'd9994; want[1] = 14'd10004; want[2] = 14'h3fff; want[3] = 14'h3fff;
    wpres = 4'b0011;
    hardware_latency = 6;
    do_arm();
    n_cmp++; if (st_act !== 6'b100000) begin n_bad++; $display("FAIL basic_busy got %b want %b", st_act, 6'b100000); end
    send(0, 10000); send(1, 10010); send(2, 14'h3fff);
    n_cmp++; if (table_complete !== 1'b0) begin n_bad++; $display("FAIL basic_early got %b want 0", table_complete); end
    send(3, 14'h3fff);
    n_cmp++; if (st_act !== 6'b010000) begin n_bad++; $display("FAIL basic_done got %b want %b", st_act, 6'b010000); end
    for (int i = 0; i < 4; i++) begin
      rd(2'(i));
      n_cmp++;
      if (rd_act !== {1'b1, wpres[i], want[i]}) begin
        n_bad++; $display("FAIL basic_read%0d got %h want %h", i, rd_act, {1'b1, wpres[i], want[i]});
      end
    end
  endtask
  task automatic test_dup();
    do_arm();
    send(1, 100); send(1, 200); send(0, 300); send(2, 400);
    n_cmp++; if (st_act !== 6'b101000) begin n_bad++; $display("FAIL dup_status got %b want %b", st_act, 6'b101000); end
    send(3, 500);
    n_cmp++; if (st_act !== 6'b011000) begin n_bad++; $display("FAIL dup_done got %b want %b", st_act, 6'b011000); end
    rd(1);
    n_cmp++; if (rd_act !== {2'b11, 14'd194}) begin n_bad++; $display("FAIL dup_read got %h want %h", rd_act, {2'b11, 14'd194}); end
  endtask
  task automatic test_underflow();
    hardware_latency = 50;
    do_arm();
    send(0, 20);
    n_cmp++; if (st_act !== 6'b100100) begin n_bad++; $display("FAIL uf_status got %b want %b", st_act, 6'b100100); end
    rd(0);
    n_cmp++; if (rd_act !== 16'hc000) begin n_bad++; $display("FAIL uf_read got %h want %h", rd_act, 16'hc000); end
    send(1, 50);
    rd(1);
    n_cmp++; if (rd_act !== 16'hc000) begin n_bad++; $display("FAIL equal_read got %h want %h", rd_act, 16'hc000); end
  endtask
  task automatic test_timeout();
    hardware_latency = 5;
    do_arm();
    send(2, 1005); send(3, 2005);
    idle(63);
    n_cmp++; if (st_act !== m_status() || capture_busy !== 1'b1) begin n_bad++; $display("FAIL wd_63 got %b want %b", st_act, m_status()); end
    idle(1);
    n_cmp++; if (st_act !== 6'b000001) begin n_bad++; $display("FAIL wd_64 got %b want %b", st_act, 6'b000001); end
    rd(2);
    n_cmp++; if (rd_act !== {2'b11, 14'd1000}) begin n_bad++; $display("FAIL wd_read2 got %h want %h", rd_act, {2'b11, 14'd1000}); end
    rd(3);
    n_cmp++; if (rd_act !== {2'b11, 14'd2000}) begin n_bad++; $display("FAIL wd_read3 got %h want %h", rd_act, {2'b11, 14'd2000}); end
    idle(1);
    n_cmp++; if (rd_act !== {2'b01, 14'd2000}) begin n_bad++; $display("FAIL rd_hold got %h want %h", rd_act, {2'b01, 14'd2000}); end
  endtask
  task automatic test_overflow_arm();
    hardware_latency = 10;
    do_arm();
    send(0, 111); send(1, 222); send(2, 333); send(3, 444);
    send(0, 999);
    n_cmp++; if (st_act !== 6'b010010) begin n_bad++; $display("FAIL ovf_status got %b want %b", st_act, 6'b010010); end
    rd(0);
    n_cmp++; if (rd_act !== {2'b11, 14'd101}) begin n_bad++; $display("FAIL ovf_table got %h want %h", rd_act, {2'b11, 14'd101}); end
    step(1, 1, 2, 777, 0, 0);
    n_cmp++; if (st_act !== 6'b100000) begin n_bad++; $display("FAIL armv_status got %b want %b", st_act, 6'b100000); end
    rd(2);
    n_cmp++; if (rd_act !== {2'b10, 14'd323}) begin n_bad++; $display("FAIL armv_drop got %h want %h", rd_act, {2'b10, 14'd323}); end
    send(2, 1010);
    n_cmp++; if (st_act !== 6'b100000) begin n_bad++; $display("FAIL armv_wrclr got %b want %b", st_act, 6'b100000); end
  endtask
  task automatic test_reset_mid();
    hardware_latency = 1;
    do_arm();
    send(0, 11); send(1, 21); send(2, 31);
    do_reset();
    n_cmp++; if ({st_act, rd_act} !== 22'h0) begin n_bad++; $display("FAIL rst_mid got %h want 0", {st_act, rd_act}); end
    do_arm();
    send(3, 41); send(2, 51); send(1, 61);
    n_cmp++; if (st_act !== 6'b100000) begin n_bad++; $display("FAIL rst_cnt got %b want %b", st_act, 6'b100000); end
    send(0, 71);
    n_cmp++; if (st_act !== 6'b010000) begin n_bad++; $display("FAIL rst_done got %b want %b", st_act, 6'b010000); end
  endtask
  task automatic test_back_to_back();
    hardware_latency = 100;
    do_arm();
    step(0, 1, 1, 500, 1, 1);
    n_cmp++; if (rd_act !== {2'b11, 14'd400}) begin n_bad++; $display("FAIL bypass got %h want %h", rd_act, {2'b11, 14'd400}); end
    step(1, 0, 0, 0, 1, 1);
    n_cmp++; if (rd_act !== {2'b10, 14'd400}) begin n_bad++; $display("FAIL bypass_arm got %h want %h", rd_act, {2'b10, 14'd400}); end
  endtask
  task automatic test_random();
    logic [13:0] d;
    for (int r = 0; r < 30; r++) begin
      hardware_latency = 14'($urandom_range(0, 3000));
      do_arm();
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0: d = 14'h3fff;
          1: d = 14'($urandom_range(0, 3000));
          default: d = 14'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 1, 2'($urandom));
        else step($urandom_range(0, 19) == 0, 1, 2'($urandom), d, 1'($urandom), 2'($urandom));
        n_cmp++; if (st_act !== m_status()) begin n_bad++; $display("FAIL rnd_status r%0d k%0d got %b want %b", r, k, st_act, m_status()); end
        n_cmp++; if (rd_act !== m_rd()) begin n_bad++; $display("FAIL rnd_read r%0d k%0d got %h want %h", r, k, rd_act, m_rd()); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_underflow();
    test_timeout();
    test_overflow_arm();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
